regfile_wb_arbiter: RTL and testbench
=====================================

# regfile_wb_arbiter

Write-port controller for the 32x32 MIPS register bank. Shares the bank's single write port (we3/a3/wd3) among N_REQ writeback requesters with round-robin arbitration. Keeps a pending-write scoreboard so decode can detect RAW hazards. After reset, sequences a zero-fill of registers 1..31 before any writeback is accepted.

## Interface
- N_REQ, 3, number of writeback requesters (2..4); index 0 = ALU, 1 = load, 2 = mul/div by convention
- clk  in  1  single clock; all state updates on posedge
- rst  in  1  synchronous, active-high reset
- req_valid  in  N_REQ  requester i has a write pending
- req_addr  in  N_REQ*5  destination register of requester i, slice [5i+4:5i]
- req_data  in  N_REQ*32  write data of requester i, slice [32i+31:32i]
- req_ready  out  N_REQ  one-hot grant; the write is accepted when valid && ready
- we3  out  1  register bank write enable
- a3  out  5  register bank write address
- wd3  out  32  register bank write data
- sb_set  in  1  decode issued an instruction that writes sb_addr
- sb_addr  in  5  destination being marked pending
- q1, q2  in  5  source registers to check (decode's a1/a2)
- busy1, busy2  out  1  q1/q2 has a pending write
- init_done  out  1  high once the zero-fill has completed

## Operation
- States: INIT and RUN. rst forces INIT with fill index 1, rr_ptr 0, all scoreboard bits 0.
- INIT:
  - each cycle we3=1, a3=index, wd3=0, req_ready=0;
  - index increments 1..31; after the index-31 write, next state is RUN;
  - sb_set is ignored in INIT.
- RUN arbitration (combinational grant, registered pointer):
  - scan requesters starting at rr_ptr, wrapping modulo N_REQ; grant the first with req_valid=1;
  - at most one req_ready bit is high, and only for a valid requester;
  - on a grant to requester g, rr_ptr <= (g+1) mod N_REQ; with no grant, rr_ptr holds.
- Write-port drive in RUN:
  - we3 = granted && req_addr[g] != 0; a3 = req_addr[g]; wd3 = req_data[g];
  - with no grant, we3=0, a3=0, wd3=0;
  - a request to address 0 is still accepted (handshake completes) but no write is issued.
- Scoreboard: 32 pending bits; bit 0 is constant 0.
  - set on sb_set (RUN only, sb_addr != 0);
  - cleared when a write to that address is accepted;
  - same address set and cleared in the same cycle: set wins, so the bit stays 1 for the newer producer.
- busy1/busy2 = pending[q1]/pending[q2], taken from registered bits. A clear in the current cycle is not bypassed; the bit drops the next cycle.
- Requesters must hold valid/addr/data stable until accepted. Violations are not checked.

## Timing
- Reset values: req_ready=0, we3=1, a3=1, wd3=0, busy1=busy2=0, init_done=0. we3=1 and a3=1 hold because the first INIT write is issued in the cycle after rst deasserts.
- INIT lasts 31 cycles after rst deasserts. init_done rises in the first RUN cycle.
- Grant latency is zero: valid in cycle N gives ready in cycle N, and the bank writes at the closing edge of cycle N.
- Scoreboard set and clear take effect at the cycle's closing edge and are visible on busy* in cycle N+1.
- Throughput: one write per cycle. A continuously valid requester is served at least once every N_REQ cycles.
- rst asserted mid-RUN or mid-INIT: the next cycle is INIT at index 1, and in-flight requests are dropped (no ready).

## Structure
- Package regfile_pkg holds:
  - NUM_REGS=32, REG_AW=5, DATA_W=32;
  - typedef enum {INIT, RUN} for the state;
  - typedefs reg_addr_t and reg_data_t.
- One sub-module, rr_arbiter: N-way round-robin with req, grant and pointer update. It is reusable later for memory-port sharing.

## Test plan
- Release rst → 31 cycles with we3=1, a3=1..31, wd3=0, ready=0; then init_done=1 and we3=0.
- In RUN, all 3 valid continuously with addresses 5/6/7 → grants cycle 0,1,2,0…; a3 sequence 5,6,7,5; no requester starved.
- Requester 1 writes addr 0, data 0xDEADBEEF → req_ready[1]=1, we3=0, no scoreboard change.
- sb_set addr 9, then requester 0 writes 9 two cycles later → busy1 (q1=9) is 1 from the cycle after the set until the cycle after the write.
- Same cycle: sb_set addr 12 and an accepted write to 12 → busy stays 1.
- Assert rst mid-RUN while requests are pending → ready=0 the next cycle, busy cleared, fill restarts at a3=1.

Source files
------------

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared widths, state encoding and register types for the register-bank write port
package regfile_pkg;
    localparam int NUM_REGS = 32;
    localparam int REG_AW = 5;
    localparam int DATA_W = 32;
    typedef enum logic {INIT, RUN} state_t;
    typedef logic [REG_AW-1:0] reg_addr_t;
    typedef logic [DATA_W-1:0] reg_data_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: N-way round-robin arbiter, combinational grant with a registered priority pointer
module rr_arbiter #(
    parameter int N = 3,
    localparam int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req,
    output logic [N-1:0]  grant,
    output logic [PW-1:0] gidx,
    output logic          any
);
    logic [PW-1:0] ptr;
    logic [PW-1:0] j;
    always_comb begin
        grant = '0;
        gidx = '0;
        any = 1'b0;
        j = '0;
        for (int k = 0; k < N; k++) begin
            j = PW'((int'(ptr) + k) % N);
            if (!any && req[j]) begin
                grant[j] = 1'b1;
                gidx = j;
                any = 1'b1;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (rst) ptr <= '0;
        else if (any) ptr <= (int'(gidx) == N - 1) ? '0 : gidx + 1'b1;
    end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: shares the register bank write port among writeback requesters,
// zero-fills r1..r31 after reset and tracks pending writes for RAW hazard detection
module regfile_wb_arbiter
    import regfile_pkg::*;
#(
    parameter int N_REQ = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ*REG_AW-1:0] req_addr,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    output logic [N_REQ-1:0]        req_ready,
    output logic                    we3,
    output reg_addr_t               a3,
    output reg_data_t               wd3,
    input  logic                    sb_set,
    input  reg_addr_t               sb_addr,
    input  reg_addr_t               q1,
    input  reg_addr_t               q2,
    output logic                    busy1,
    output logic                    busy2,
    output logic                    init_done
);
    localparam int PW = $clog2(N_REQ);
    state_t state, state_nxt;
    reg_addr_t idx, ga;
    reg_data_t gd;
    logic [NUM_REGS-1:0] pend, pend_nxt;
    logic running, any;
    logic [PW-1:0] gidx;
    logic [N_REQ-1:0] arb_req;
    // Requests are masked while rst is high so nothing is accepted in the reset cycle
    assign running = (state == RUN) && !rst;
    assign arb_req = running ? req_valid : '0;
    rr_arbiter #(.N(N_REQ)) u_arb (
        .clk  (clk),
        .rst  (rst),
        .req  (arb_req),
        .grant(req_ready),
        .gidx (gidx),
        .any  (any)
    );
    assign ga = req_addr[int'(gidx)*REG_AW +: REG_AW];
    assign gd = req_data[int'(gidx)*DATA_W +: DATA_W];
    always_comb begin
        state_nxt = (state == INIT && idx == reg_addr_t'(NUM_REGS - 1)) ? RUN : state;
        we3 = running ? (any && ga != '0) : 1'b1;
        a3 = running ? (any ? ga : '0) : (rst ? reg_addr_t'(1) : idx);
        wd3 = (running && any) ? gd : '0;
        pend_nxt = pend;
        if (running && any) pend_nxt[ga] = 1'b0;
        if (running && sb_set) pend_nxt[sb_addr] = 1'b1;
        pend_nxt[0] = 1'b0;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= INIT;
            idx <= reg_addr_t'(1);
            pend <= '0;
        end else begin
            state <= state_nxt;
            idx <= (state == INIT) ? idx + 1'b1 : idx;
            pend <= pend_nxt;
        end
    end
    assign busy1 = pend[q1];
    assign busy2 = pend[q2];
    assign init_done = (state == RUN);
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: scenario tasks plus randomized traffic checked against a behavioural model
module tb_regfile_wb_arbiter;
    localparam int N = 3;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [N-1:0] req_valid, req_ready;
    logic [N*5-1:0] req_addr;
    logic [N*32-1:0] req_data;
    logic we3, sb_set, busy1, busy2, init_done;
    logic [4:0] a3, sb_addr, q1, q2;
    logic [31:0] wd3;
    int tests = 0;
    int fails = 0;
    bit rv[N];
    logic [4:0] ra[N];
    logic [31:0] rd[N];
    int m_ptr;
    bit [31:0] m_pend;
    bit m_run;

    regfile_wb_arbiter #(.N_REQ(N)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
        .req_ready(req_ready), .we3(we3), .a3(a3), .wd3(wd3), .sb_set(sb_set), .sb_addr(sb_addr),
        .q1(q1), .q2(q2), .busy1(busy1), .busy2(busy2), .init_done(init_done)
    );

    always #5 clk = ~clk;

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            req_valid[i] = rv[i];
            req_addr[i*5 +: 5] = ra[i];
            req_data[i*32 +: 32] = rd[i];
        end
        #1;
    endtask

    function automatic int exp_grant();
        for (int k = 0; k < N; k++) begin
            int j;
            j = (m_ptr + k) % N;
            if (rv[j]) return j;
        end
        return -1;
    endfunction

    task automatic tick();
        int g;
        if (m_run) begin
            g = exp_grant();
            if (g >= 0) begin
                m_pend[ra[g]] = 1'b0;
                m_ptr = (g + 1) % N;
            end
            if (sb_set && sb_addr != 0) m_pend[sb_addr] = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        sb_set = 1'b0; sb_addr = '0; q1 = '0; q2 = '0;
        for (int i = 0; i < N; i++) begin rv[i] = 0; ra[i] = '0; rd[i] = '0; end
        drive();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        m_ptr = 0; m_pend = '0; m_run = 1'b0;
        for (int i = 1; i <= 31; i++) begin
            for (int r = 0; r < N; r++) begin rv[r] = 1; ra[r] = 5'($urandom_range(1, 31)); rd[r] = $urandom; end
            sb_set = 1'b1; sb_addr = 5'd3; q1 = 5'd3;
            drive();
            tests++;
            if (we3 !== 1'b1 || a3 !== 5'(i) || wd3 !== 32'h0 || req_ready !== '0 || init_done !== 1'b0 || busy1 !== 1'b0) begin
                fails++;
                $display("FAIL init_fill[%0d]: got we3=%b a3=%0d wd3=%h ready=%b done=%b busy1=%b, need 1 %0d 0 000 0 0",
                         i, we3, a3, wd3, req_ready, init_done, busy1, i);
            end
            tick();
        end
        m_run = 1'b1;
        for (int r = 0; r < N; r++) rv[r] = 0;
        sb_set = 1'b0;
        drive();
        tests++;
        if (init_done !== 1'b1 || we3 !== 1'b0 || busy1 !== 1'b0 || req_ready !== '0) begin
            fails++;
            $display("FAIL init_end: got done=%b we3=%b busy1=%b ready=%b, need 1 0 0 000", init_done, we3, busy1, req_ready);
        end
        tick();
    endtask

    task automatic test_rr();
        int cnt[N];
        for (int i = 0; i < N; i++) begin rv[i] = 1; ra[i] = 5'(5 + i); rd[i] = $urandom; cnt[i] = 0; end
        for (int c = 0; c < 6; c++) begin
            int g;
            g = c % N;
            drive();
            tests++;
            if (req_ready !== (N'(1) << g) || we3 !== 1'b1 || a3 !== 5'(5 + g) || wd3 !== rd[g]) begin
                fails++;
                $display("FAIL rr_cycle%0d: got ready=%b we3=%b a3=%0d wd3=%h, need ready=%b we3=1 a3=%0d wd3=%h",
                         c, req_ready, we3, a3, wd3, N'(1) << g, 5 + g, rd[g]);
            end
            for (int i = 0; i < N; i++) cnt[i] += int'(req_ready[i]);
            tick();
        end
        for (int i = 0; i < N; i++) begin
            tests++;
            if (cnt[i] != 2) begin
                fails++;
                $display("FAIL rr_fair[%0d]: got %0d grants, need 2", i, cnt[i]);
            end
        end
        for (int i = 0; i < N; i++) rv[i] = 0;
    endtask

    task automatic test_addr0();
        rv[1] = 1; ra[1] = 5'd0; rd[1] = 32'hDEADBEEF; q1 = 5'd0;
        drive();
        tests++;
        if (req_ready !== 3'b010 || we3 !== 1'b0 || a3 !== 5'd0 || wd3 !== 32'hDEADBEEF || busy1 !== 1'b0) begin
            fails++;
            $display("FAIL addr0: got ready=%b we3=%b a3=%0d wd3=%h busy1=%b, need 010 0 0 deadbeef 0",
                     req_ready, we3, a3, wd3, busy1);
        end
        tick();
        rv[1] = 0;
        drive();
        tests++;
        if (busy1 !== 1'b0 || req_ready !== '0 || we3 !== 1'b0) begin
            fails++;
            $display("FAIL addr0_after: got busy1=%b ready=%b we3=%b, need 0 000 0", busy1, req_ready, we3);
        end
        tick();
    endtask

    task automatic test_sb_raw();
        sb_set = 1'b1; sb_addr = 5'd9; q1 = 5'd9;
        drive();
        tests++;
        if (busy1 !== 1'b0) begin fails++; $display("FAIL raw_set_cycle: got busy1=%b, need 0", busy1); end
        tick();
        sb_set = 1'b0;
        drive();
        tests++;
        if (busy1 !== 1'b1) begin fails++; $display("FAIL raw_pending: got busy1=%b, need 1", busy1); end
        tick();
        rv[0] = 1; ra[0] = 5'd9; rd[0] = $urandom;
        drive();
        tests++;
        if (busy1 !== 1'b1 || req_ready !== 3'b001 || we3 !== 1'b1 || a3 !== 5'd9 || wd3 !== rd[0]) begin
            fails++;
            $display("FAIL raw_write: got busy1=%b ready=%b we3=%b a3=%0d wd3=%h, need 1 001 1 9 %h",
                     busy1, req_ready, we3, a3, wd3, rd[0]);
        end
        tick();
        rv[0] = 0;
        drive();
        tests++;
        if (busy1 !== 1'b0) begin fails++; $display("FAIL raw_cleared: got busy1=%b, need 0", busy1); end
        tick();
    endtask

    task automatic test_same_cycle();
        sb_set = 1'b1; sb_addr = 5'd12; q2 = 5'd12;
        drive();
        tick();
        rv[2] = 1; ra[2] = 5'd12; rd[2] = $urandom;
        drive();
        tests++;
        if (req_ready !== 3'b100 || busy2 !== 1'b1 || we3 !== 1'b1 || a3 !== 5'd12) begin
            fails++;
            $display("FAIL same_cycle_write: got ready=%b busy2=%b we3=%b a3=%0d, need 100 1 1 12", req_ready, busy2, we3, a3);
        end
        tick();
        rv[2] = 0; sb_set = 1'b0;
        drive();
        tests++;
        if (busy2 !== 1'b1) begin fails++; $display("FAIL same_cycle_set_wins: got busy2=%b, need 1", busy2); end
        tick();
    endtask

    task automatic test_random();
        for (int c = 0; c < 300; c++) begin
            int g;
            logic [N-1:0] er;
            for (int i = 0; i < N; i++) begin
                if (!rv[i] && $urandom_range(0, 1) == 1) begin
                    rv[i] = 1;
                    ra[i] = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
                    rd[i] = $urandom;
                end
            end
            sb_set = ($urandom_range(0, 2) == 0);
            sb_addr = 5'($urandom);
            q1 = 5'($urandom);
            q2 = ($urandom_range(0, 1) == 0) ? ra[$urandom_range(0, N - 1)] : 5'($urandom);
            drive();
            g = exp_grant();
            er = (g < 0) ? '0 : N'(1) << g;
            tests++;
            if (req_ready !== er
                || we3 !== (g >= 0 && ra[g] != 0)
                || a3 !== ((g < 0) ? 5'd0 : ra[g])
                || wd3 !== ((g < 0) ? 32'd0 : rd[g])
                || busy1 !== m_pend[q1] || busy2 !== m_pend[q2]) begin
                fails++;
                $display("FAIL random[%0d]: got ready=%b we3=%b a3=%0d wd3=%h b1=%b b2=%b, need ready=%b we3=%b a3=%0d wd3=%h b1=%b b2=%b",
                         c, req_ready, we3, a3, wd3, busy1, busy2, er, (g >= 0 && ra[g] != 0),
                         (g < 0) ? 5'd0 : ra[g], (g < 0) ? 32'd0 : rd[g], m_pend[q1], m_pend[q2]);
            end
            tick();
            if (g >= 0) rv[g] = 0;
        end
        sb_set = 1'b0;
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < N; i++) begin rv[i] = 1; ra[i] = 5'($urandom_range(1, 31)); rd[i] = $urandom; end
        sb_set = 1'b1; sb_addr = 5'd20; q1 = 5'd20;
        ra[0] = 5'd21; ra[1] = 5'd22; ra[2] = 5'd23;
        drive();
        tick();
        sb_set = 1'b0;
        drive();
        tests++;
        if (busy1 !== 1'b1) begin fails++; $display("FAIL mid_pre_busy: got busy1=%b, need 1", busy1); end
        rst = 1'b1;
        drive();
        @(posedge clk);
        #1;
        rst = 1'b0;
        m_ptr = 0; m_pend = '0; m_run = 1'b0;
        for (int i = 1; i <= 31; i++) begin
            drive();
            tests++;
            if (req_ready !== '0 || busy1 !== 1'b0 || we3 !== 1'b1 || a3 !== 5'(i) || init_done !== 1'b0) begin
                fails++;
                $display("FAIL mid_refill[%0d]: got ready=%b busy1=%b we3=%b a3=%0d done=%b, need 000 0 1 %0d 0",
                         i, req_ready, busy1, we3, a3, init_done, i);
            end
            tick();
        end
        m_run = 1'b1;
        for (int i = 0; i < N; i++) rv[i] = 0;
        rv[1] = 1;
        drive();
        tests++;
        if (init_done !== 1'b1 || req_ready !== 3'b010 || a3 !== 5'd22) begin
            fails++;
            $display("FAIL mid_resume: got done=%b ready=%b a3=%0d, need 1 010 22", init_done, req_ready, a3);
        end
        tick();
        rv[1] = 0;
    endtask

    initial begin
        test_reset();
        test_rr();
        test_addr0();
        test_sb_raw();
        test_same_cycle();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
